// File: rtl/req_arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package req_arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

endpackage

// File: rtl/req_arbiter4_rr_pick.sv
// Rotated priority encoder: first set request bit scanning from ptr upward (mod 4).
module rr_pick
    import req_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] sel,
    output logic             any_req
);

    logic             found;
    logic [IDX_W-1:0] idx;

    assign any_req = |req;

    // Walk ptr, ptr+1, ... and latch the first requester seen; idx wraps naturally at 2 bits.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester round-robin arbiter with hold-until-release grants and a hold timeout.
module req_arbiter4
    import req_arb_pkg::state_e;
    import req_arb_pkg::IDLE;
    import req_arb_pkg::GRANT;
    import req_arb_pkg::IDX_W;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rel,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    state_e            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] cnt;
    logic [IDX_W-1:0]  sel;
    logic              any_req;
    logic              rel_cond;
    logic              hold_max;

    rr_pick u_rr_pick (
        .req     (req),
        .ptr     (ptr),
        .sel     (sel),
        .any_req (any_req)
    );

    // Only the holder's own rel/req bits can end a grant.
    assign rel_cond = rel[gnt_idx] | ~req[gnt_idx];
    assign hold_max = (cnt == HOLD_W'(MAX_HOLD - 1));

    // Arbitration FSM with registered grant outputs, rotation pointer and hold counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt     <= NREQ'(1) << sel;
                        gnt_idx <= sel;
                        busy    <= 1'b1;
                        ptr     <= sel + IDX_W'(1);
                        cnt     <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_cond || hold_max) begin
                        // A voluntary release wins over the limit, so no timeout pulse then.
                        gnt     <= '0;
                        busy    <= 1'b0;
                        timeout <= ~rel_cond;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed bench for req_arbiter4 with hand-computed expectations.
module tb_req_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] rel;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    req_arbiter4 #(
        .NREQ     (4),
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                              input logic eb, input logic et);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {gnt, gnt_idx, busy, timeout};
        exp = {eg, ei, eb, et};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed gnt=%b idx=%0d busy=%b timeout=%b, expected gnt=%b idx=%0d busy=%b timeout=%b",
                   tag, gnt, gnt_idx, busy, timeout, eg, ei, eb, et);
        end
        checks++;
        assert ($onehot0(gnt)) else begin
            errors++;
            $error("FAIL %s_onehot: observed gnt=%b, expected one-hot or zero", tag, gnt);
        end
    endtask

    task automatic expect_grant(input string tag, input int h);
        logic [3:0] oh;
        oh = 4'b0001 << h;
        expect_out(tag, oh, 2'(h), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        rel = 4'b0000;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        rel = 4'b0000;
        tick(2);
        rst = 1'b0;
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Basic grant, release, dead cycle, rotation to 2.
        req = 4'b0101;
        tick(1);
        expect_grant("t1_first", 0);
        rel = 4'b0001;
        tick(1);
        rel = 4'b0000;
        expect_out("t1_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_grant("t1_next", 2);
        req = 4'b0000;
        tick(1);
        expect_out("t1_reqdrop", 4'b0000, 2'd2, 1'b0, 1'b0);
        tick(1);
        expect_out("t1_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // All four requesting: 0,1,2,3,0 with one dead cycle each.
        do_reset();
        expect_out("t2_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1111;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            expect_grant($sformatf("t2_gnt%0d", k), k % 4);
            tick(1);
            expect_grant($sformatf("t2_hold%0d", k), k % 4);
            rel = 4'b0001 << (k % 4);
            tick(1);
            rel = 4'b0000;
            expect_out($sformatf("t2_dead%0d", k), 4'b0000, 2'(k % 4), 1'b0, 1'b0);
            tick(1);
        end
        expect_grant("t2_wrap", 1);
        req = 4'b0000;
        tick(2);
        expect_out("t2_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

        // Hold timeout on a lone requester 1.
        do_reset();
        req = 4'b0010;
        tick(1);
        expect_grant("t3_start", 1);
        for (int i = 1; i < 16; i++) begin
            tick(1);
            expect_grant($sformatf("t3_hold%0d", i), 1);
        end
        tick(1);
        expect_out("t3_timeout", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick(1);
        expect_grant("t3_regrant", 1);
        // ptr is now 2: with 1 and 2 both pending, 2 must win next.
        req = 4'b0111;
        rel = 4'b0010;
        tick(1);
        rel = 4'b0000;
        expect_out("t3_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
        tick(1);
        expect_grant("t3_ptr2", 2);
        req = 4'b0000;
        tick(2);

        // Foreign rel ignored; dropping req[3] releases; ptr wraps to 0.
        do_reset();
        req = 4'b1000;
        tick(1);
        expect_grant("t4_gnt3", 3);
        req = 4'b1001;
        rel = 4'b0001;
        tick(1);
        rel = 4'b0000;
        expect_grant("t4_ignore_rel0", 3);
        tick(1);
        expect_grant("t4_hold", 3);
        req = 4'b0001;
        tick(1);
        expect_out("t4_drop", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick(1);
        expect_grant("t4_wrap0", 0);
        req = 4'b0000;
        tick(2);

        // Release coinciding with the last hold cycle: no timeout.
        req = 4'b0001;
        tick(1);
        expect_grant("t5_start", 0);
        tick(15);
        expect_grant("t5_last", 0);
        rel = 4'b0001;
        tick(1);
        rel = 4'b0000;
        req = 4'b0000;
        expect_out("t5_rel_at_max", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_out("t5_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset in the fifth cycle of a grant to 2.
        do_reset();
        req = 4'b0100;
        tick(1);
        expect_grant("t6_gnt2", 2);
        tick(4);
        expect_grant("t6_cycle5", 2);
        rst = 1'b1;
        req = 4'b0110;
        tick(1);
        rst = 1'b0;
        expect_out("t6_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick(1);
        expect_grant("t6_after", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
